serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  - Bit-serial N-bit subtractor; computes diff = a - b and borrow-out, one bit per clock, LSB first.
//  - Inverse-direction companion to the combinational adder datapath.
//  - Sits in the arithmetic unit, where area matters more than latency.
//  - start/ready/done handshake to a controlling FSM.
// PARAMETERS
//  - WIDTH  8  operand/result width in bits; legal range >= 2
// PORTS
//  - clk    in   1      single clock, rising edge
//  - reset  in   1      asynchronous, active-high; all state cleared immediately
//  - start  in   1      request; accepted only when ready=1
//  - a      in   WIDTH  minuend, sampled on the accept cycle only
//  - b      in   WIDTH  subtrahend, sampled on the accept cycle only
//  - ready  out  1      high in IDLE; block can accept start
//  - done   out  1      one-cycle pulse; diff/bout valid
//  - diff   out  WIDTH  a - b modulo 2^WIDTH, registered
//  - bout   out  1      final borrow; 1 iff a < b, unsigned
//  - ovf    out  1      signed overflow; present only with SERIAL_SUB_OVF_EN
// BEHAVIOUR
//  - Reset values: state=IDLE, ready=1, done=0, diff=0, bout=0, ovf=0, borrow FF=0, counter=0.
//  - FSM states: IDLE, SHIFT, DONE.
//    - IDLE -> SHIFT on start. Load a/b into shift registers, clear borrow, counter=0.
//    - SHIFT -> DONE when counter == WIDTH-1 after processing that bit; otherwise counter++.
//    - DONE -> IDLE unconditionally after one cycle.
//  - Per SHIFT cycle, with x=a_sr[0], y=b_sr[0], br=borrow FF:
//    - d = x^y^br
//    - br_next = (~x&y) | (~(x^y)&br)
//    - d shifts into the result register at the MSB; a_sr and b_sr shift right.
//  - Timing: start accepted at edge T.
//    - ready=0 from T+1.
//    - SHIFT occupies cycles T+1..T+WIDTH.
//    - done=1 in cycle T+WIDTH+1, with diff and bout updated in that same cycle.
//    - ready=1 again at T+WIDTH+2.
//    - Total latency is WIDTH+1 cycles.
//  - diff/bout/ovf hold their value after done until the next completion; partial results are never visible.
//  - start while ready=0 (SHIFT or DONE) is ignored and not queued; a/b changes outside the accept cycle have no effect.
//  - Back-to-back: start held high is accepted on the first cycle ready=1, i.e. the cycle after DONE.
//  - Reset mid-operation aborts the operation: outputs return to reset values, no done pulse is emitted.
//  - Counter width is $clog2(WIDTH); it never wraps past WIDTH-1.
// CONFIGURATION
//  - SERIAL_SUB_OVF_EN defined:
//    - Port ovf exists.
//    - MSBs of a and b are latched at accept.
//    - ovf = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb), registered with diff.
//  - SERIAL_SUB_OVF_EN undefined: ovf port and its latches are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package arith_pkg:
//    - FSM state encoding: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
//    - Default WIDTH constant.
//  - Sub-module full_subtractor (combinational; x, y, bin -> d, bout) implements the per-bit cell.
//  - Top level holds the FSM, counter, shift registers, borrow FF and output registers.
// TESTING (WIDTH=8)
//  - a=0x35, b=0x12, start 1 cycle -> done exactly 9 cycles later; diff=0x23, bout=0.
//  - a=0x00, b=0x01 -> diff=0xFF, bout=1; a=0xAA, b=0xAA -> diff=0x00, bout=0.
//  - Pulse start again at cycle 3 of busy with a=0xFF -> ignored; result still from the original operands, single done.
//  - Assert reset at SHIFT cycle 4 -> ready=1, done never pulses, diff=0, bout=0; a new op then completes correctly.
//  - start held high for 3 ops (0x10-0x01, 0x01-0x10, 0x7F-0x7F):
//    - accepts occur 10 cycles apart;
//    - results 0x0F/0, 0xF1/1, 0x00/0.
//  - OVF_EN: 0x80-0x01 -> diff=0x7F, ovf=1; 0x7F-0xFF -> diff=0x80, ovf=1; 0x05-0x03 -> ovf=0.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: FSM state encoding and default datapath width.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor (diff = a - b, LSB first) with start/ready/done handshake.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic             w_ready;
    logic             w_done;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic             r_borrow;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             w_d;
    logic             w_bout;
    logic             w_last;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_ovf;
`endif

    assign w_last = (r_cnt == LAST);

    full_subtractor u_cell (
        .x    (r_a_sr[0]),
        .y    (r_b_sr[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (start) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // The minuend register doubles as the result register: each difference bit
    // enters at the MSB as the consumed operand bit leaves at the LSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_borrow <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        r_a_msb  <= a[WIDTH-1];
                        r_b_msb  <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    r_a_sr   <= {w_d, r_a_sr[WIDTH-1:1]};
                    r_b_sr   <= r_b_sr >> 1;
                    r_borrow <= w_bout;
                    if (w_last) begin
                        r_diff <= {w_d, r_a_sr[WIDTH-1:1]};
                        r_bout <= w_bout;
`ifdef SERIAL_SUB_OVF_EN
                        r_ovf  <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready = w_ready;
    assign done  = w_done;
    assign diff  = r_diff;
    assign bout  = r_bout;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8); define SERIAL_SUB_OVF_EN to also cover ovf.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
        int               doneEdge;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    exp_t q[$];
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   doneCount = 0;
    int   pushCount = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
       ,.ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pushExpected(input logic [WIDTH-1:0] d, input logic bo, input logic ov, input int edgeNo);
        exp_t e;
        e.diff     = d;
        e.bout     = bo;
        e.ovf      = ov;
        e.doneEdge = edgeNo;
        q.push_back(e);
        pushCount++;
    endtask

    // Waits for the handshake, issues one start pulse and queues the expected result.
    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic [WIDTH-1:0] expDiff, input logic expBout,
                                 input logic expOvf);
        int n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("ready before start", 32'(ready), 32'd1);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk); #1;
        pushExpected(expDiff, expBout, expOvf, cyc + WIDTH);
        start = 1'b0;
        a     = 8'h5A;
        b     = 8'hC3;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((q.size() != 0 || !ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("idle reached", 32'(n < 100), 32'd1);
    endtask

    // Monitor: every done cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            doneCount++;
            if (q.size() == 0) begin
                checkOutput("unexpected done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                checkOutput("diff", 32'(diff), 32'(e.diff));
                checkOutput("bout", 32'(bout), 32'(e.bout));
                checkOutput("done latency", 32'(cyc), 32'(e.doneEdge));
`ifdef SERIAL_SUB_OVF_EN
                checkOutput("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset ready", 32'(ready), 32'd1);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset diff", 32'(diff), 32'd0);
        checkOutput("reset bout", 32'(bout), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] basic vectors");
        applyStimulus(8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
        checkOutput("busy after accept", 32'(ready), 32'd0);
        waitIdle();
        applyStimulus(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        waitIdle();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold diff", 32'(diff), 32'hFF);
        checkOutput("hold bout", 32'(bout), 32'd1);
        applyStimulus(8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0);
        waitIdle();

        $display("[TB] start while busy is ignored");
        applyStimulus(8'h50, 8'h20, 8'h30, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("busy ready", 32'(ready), 32'd0);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
        @(posedge clk); #1;
        start = 1'b0;
        waitIdle();
        repeat (12) @(posedge clk);
        #1;

        $display("[TB] reset mid-operation");
        start = 1'b1;
        a     = 8'h35;
        b     = 8'h12;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort ready", 32'(ready), 32'd1);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort diff", 32'(diff), 32'd0);
        checkOutput("abort bout", 32'(bout), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        applyStimulus(8'h0C, 8'h05, 8'h07, 1'b0, 1'b0);
        waitIdle();

        $display("[TB] start held high, back-to-back");
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h01;
        @(posedge clk); #1;
        k = cyc;
        pushExpected(8'h0F, 1'b0, 1'b0, k + WIDTH);
        a = 8'h01;
        b = 8'h10;
        repeat (10) @(posedge clk);
        #1;
        pushExpected(8'hF1, 1'b1, 1'b0, k + 10 + WIDTH);
        a = 8'h7F;
        b = 8'h7F;
        repeat (10) @(posedge clk);
        #1;
        pushExpected(8'h00, 1'b0, 1'b0, k + 20 + WIDTH);
        start = 1'b0;
        waitIdle();

`ifdef SERIAL_SUB_OVF_EN
        $display("[TB] signed overflow");
        applyStimulus(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        waitIdle();
        applyStimulus(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        waitIdle();
        applyStimulus(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        waitIdle();
`endif

        repeat (5) @(posedge clk);
        #1;
        checkOutput("queue drained", 32'(q.size()), 32'd0);
        checkOutput("done count", 32'(doneCount), 32'(pushCount));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
